// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising four cores onto one asynchronous single-port RAM.
// Each transaction takes exactly three cycles: IDLE (grant), ACCESS (RAM pins), DONE (ack).
module mem_arbiter #(
  parameter int unsigned CORES = 4,
  parameter int unsigned SIZE  = 256,
  parameter int unsigned WORD  = 32,
  localparam int unsigned AW   = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORES-1:0]      req,
  input  logic [CORES-1:0]      we_in,
  input  logic [CORES*AW-1:0]   addr_in,
  input  logic [CORES*WORD-1:0] wdata_in,
  output logic [CORES-1:0]      ack,
  output logic [WORD-1:0]       rdata,
  output logic                  busy,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [AW-1:0]         mem_addr,
  output logic [WORD-1:0]       mem_wdata,
  input  logic [WORD-1:0]       mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       winner_q;
  logic [1:0]       last_grant_q;
  logic [CORES-1:0] ack_q;
  logic [WORD-1:0]  rdata_q;
  logic             mem_we_q, mem_re_q;
  logic [AW-1:0]    mem_addr_q;
  logic [WORD-1:0]  mem_wdata_q;

  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;

  // Search upward from last_grant+1; the 2-bit add wraps mod 4.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      last_grant_q <= 2'd3;
      ack_q        <= '0;
      rdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      unique case (state_q)
        IDLE: begin
          // RAM pins are loaded here so they are stable for the whole ACCESS cycle.
          if (grant_valid) begin
            winner_q    <= grant_idx;
            mem_we_q    <= we_in[grant_idx];
            mem_re_q    <= !we_in[grant_idx];
            mem_addr_q  <= addr_in[int'(grant_idx)*AW +: AW];
            mem_wdata_q <= wdata_in[int'(grant_idx)*WORD +: WORD];
          end
        end
        ACCESS: begin
          if (mem_re_q) rdata_q <= mem_rdata;
          ack_q       <= {{(CORES-1){1'b0}}, 1'b1} << winner_q;
          mem_we_q    <= 1'b0;
          mem_re_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        DONE: begin
          last_grant_q <= winner_q;
        end
        default: ;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin / RAM reference model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   we_in;
  logic [31:0]  addr_in;
  logic [127:0] wdata_in;
  wire  [3:0]   ack;
  wire  [31:0]  rdata;
  wire          busy;
  wire          mem_we;
  wire          mem_re;
  wire  [7:0]   mem_addr;
  wire  [31:0]  mem_wdata;
  wire  [31:0]  mem_rdata;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we_in     (we_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Asynchronous RAM attached to the arbiter
  logic [31:0] ram [256];
  assign mem_rdata = mem_re ? ram[mem_addr] : 'z;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  // Reference model state
  logic [31:0] model_ram [256];
  int          lg;
  logic [31:0] exp_rdata;
  bit          c_we   [4];
  logic [7:0]  c_addr [4];
  logic [31:0] c_data [4];

  int checks = 0;
  int errors = 0;

  function automatic int pick(logic [3:0] m, int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_core(int i, bit w, logic [7:0] a, logic [31:0] d);
    c_we[i]   = w;
    c_addr[i] = a;
    c_data[i] = d;
    we_in[i]            = w;
    addr_in[i*8 +: 8]   = a;
    wdata_in[i*32 +: 32] = d;
  endtask

  task automatic model_apply(int i);
    if (c_we[i]) model_ram[c_addr[i]] = c_data[i];
    else         exp_rdata = model_ram[c_addr[i]];
    lg = i;
  endtask

  // Waits for the next ack; returns vector, rdata, cycles waited and a timeout flag.
  task automatic wait_ack(output logic [3:0] av, output logic [31:0] rd,
                          output int cyc, output bit to);
    av = '0; rd = '0; cyc = 0; to = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (ack != 4'b0) begin
        av = ack; rd = rdata; cyc = n; to = 1'b0;
        for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; we_in = '0; addr_in = '0; wdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack, rdata, busy} !== 37'b0) begin
      errors++; $display("FAIL reset_ack_rdata_busy: got %h/%h/%b want 0", ack, rdata, busy);
    end
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== 42'b0) begin
      errors++;
      $display("FAIL reset_mem_pins: got we=%b re=%b addr=%h wdata=%h want 0",
               mem_we, mem_re, mem_addr, mem_wdata);
    end
    @(negedge clk) rst_n = 1'b1;
    lg = 3; exp_rdata = '0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_core(0, 1'b1, 8'h10, 32'hDEADBEEF);
    req = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_we, mem_re, mem_addr, mem_wdata} !== {3'b110, 8'h10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_access_pins: got busy=%b we=%b re=%b addr=%h wdata=%h want 1/1/0/10/deadbeef",
               busy, mem_we, mem_re, mem_addr, mem_wdata);
    end
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL wr_early_ack: got %b want 0000", ack); end
    @(posedge clk); #1;
    checks++;
    if ({ack, mem_we, rdata} !== {4'b0001, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wr_done: got ack=%b we=%b rdata=%h want 0001/0/0", ack, mem_we, rdata);
    end
    req[0] = 1'b0;
    model_apply(0);
    @(posedge clk); #1;
    checks++;
    if ({ack, busy} !== 5'b0) begin
      errors++; $display("FAIL wr_after: got ack=%b busy=%b want 0000/0", ack, busy);
    end

    @(negedge clk);
    set_core(2, 1'b0, 8'h10, $urandom);
    req = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if ({mem_re, mem_we, mem_addr} !== {2'b10, 8'h10}) begin
      errors++;
      $display("FAIL rd_access_pins: got re=%b we=%b addr=%h want 1/0/10", mem_re, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    model_apply(2);
    checks++;
    if ({ack, rdata, mem_re} !== {4'b0100, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL rd_done: got ack=%b rdata=%h re=%b want 0100/deadbeef/0", ack, rdata, mem_re);
    end
    req[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL rd_ack_width: got %b want 0000", ack); end
  endtask

  task automatic test_all_four();
    logic [3:0] av; logic [31:0] rd; int cyc; bit to; int e;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    lg = 3; exp_rdata = '0;
    for (int i = 0; i < 4; i++)
      set_core(i, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      e = pick(req, lg);
      wait_ack(av, rd, cyc, to);
      model_apply(e);
      checks++;
      if (to || av !== (4'b1 << n) || e != n || cyc != (n == 0 ? 2 : 3) || rd !== exp_rdata) begin
        errors++;
        $display("FAIL all_four[%0d]: got ack=%b cyc=%0d rdata=%h to=%b want ack=%b cyc=%0d rdata=%h",
                 n, av, cyc, rd, to, 4'b1 << n, (n == 0 ? 2 : 3), exp_rdata);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] av; logic [31:0] rd; int cyc; bit to;
    int seq [5] = '{3, 1, 3, 1, 3};
    settle();
    set_core(1, 1'b1, 8'($urandom_range(0, 7)), $urandom);
    req = 4'b0010;
    wait_ack(av, rd, cyc, to);
    model_apply(1);
    checks++;
    if (to || av !== 4'b0010) begin
      errors++; $display("FAIL fair_setup: got ack=%b to=%b want 0010", av, to);
    end
    settle();
    set_core(1, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
    set_core(3, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
    req = 4'b1010;
    for (int n = 0; n < 5; n++) begin
      wait_ack(av, rd, cyc, to);
      model_apply(seq[n]);
      checks++;
      if (to || av !== (4'b1 << seq[n]) || cyc != (n == 0 ? 2 : 3) || rd !== exp_rdata) begin
        errors++;
        $display("FAIL fair[%0d]: got ack=%b cyc=%0d rdata=%h want ack=%b rdata=%h",
                 n, av, cyc, rd, 4'b1 << seq[n], exp_rdata);
      end
      if (n < 3) begin
        set_core(seq[n], 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
        req[seq[n]] = 1'b1;
      end
    end
  endtask

  task automatic test_addr_change();
    logic [31:0] d;
    d = $urandom;
    settle();
    set_core(0, 1'b1, 8'h20, d);
    req = 4'b0001;
    @(posedge clk); #1;
    addr_in[7:0] = 8'h30; we_in[0] = 1'b0; wdata_in[31:0] = ~d;
    #2;
    checks++;
    if ({mem_addr, mem_we, mem_wdata} !== {8'h20, 1'b1, d}) begin
      errors++;
      $display("FAIL addr_change: got addr=%h we=%b wdata=%h want 20/1/%h", mem_addr, mem_we, mem_wdata, d);
    end
    @(posedge clk); #1;
    model_apply(0);
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL addr_change_ack: got %b want 0001", ack); end
    req[0] = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] av; logic [31:0] rd; int cyc; bit to;
    settle();
    set_core(1, 1'b0, 8'($urandom_range(0, 7)), $urandom);
    req = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (mem_re !== 1'b1) begin errors++; $display("FAIL abort_in_access: got re=%b want 1", mem_re); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, rdata, busy, mem_we, mem_re, mem_addr, mem_wdata} !== 79'b0) begin
      errors++;
      $display("FAIL abort_outputs: got ack=%b rdata=%h busy=%b we=%b re=%b addr=%h wdata=%h want 0",
               ack, rdata, busy, mem_we, mem_re, mem_addr, mem_wdata);
    end
    req = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL abort_no_ack: got %b want 0000", ack); end
    lg = 3; exp_rdata = '0;
    set_core(3, 1'b0, 8'($urandom_range(0, 7)), $urandom);
    req = 4'b1000;
    @(negedge clk) rst_n = 1'b1;
    wait_ack(av, rd, cyc, to);
    model_apply(3);
    checks++;
    if (to || av !== 4'b1000 || cyc != 2 || rd !== exp_rdata) begin
      errors++;
      $display("FAIL abort_recover: got ack=%b cyc=%0d rdata=%h want 1000/2/%h", av, cyc, rd, exp_rdata);
    end
  endtask

  task automatic test_random();
    logic [3:0] av; logic [31:0] rd; int cyc; bit to; int e; int round;
    settle();
    round = 0;
    while (round < 30 || req != 4'b0) begin
      if (round < 30) begin
        for (int i = 0; i < 4; i++) begin
          if (!req[i] && $urandom_range(0, 1) == 1) begin
            set_core(i, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
            req[i] = 1'b1;
          end
        end
        if (req == 4'b0) begin
          set_core(round % 4, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
          req[round % 4] = 1'b1;
        end
      end
      e = pick(req, lg);
      wait_ack(av, rd, cyc, to);
      model_apply(e);
      checks++;
      if (to || av !== (4'b1 << e) || cyc != (round == 0 ? 2 : 3) || rd !== exp_rdata) begin
        errors++;
        $display("FAIL random[%0d]: got ack=%b cyc=%0d rdata=%h to=%b want ack=%b cyc=%0d rdata=%h",
                 round, av, cyc, rd, to, 4'b1 << e, (round == 0 ? 2 : 3), exp_rdata);
      end
      round++;
      if (round > 60) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]       = $urandom;
      model_ram[i] = ram[i];
    end
    lg = 3; exp_rdata = '0;
    for (int i = 0; i < 4; i++) begin c_we[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0; end
    test_reset();
    test_write_read();
    test_all_four();
    test_fairness();
    test_addr_change();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that lets four MIPS cores share one asynchronous single-port data RAM. It sits directly upstream of the RAM. It accepts one request per core, serialises them onto the RAM's we/re/addr/wdata pins, samples the RAM's read data, and returns it to the winning core with a one-cycle acknowledge.

## Interface

Parameters:
- CORES, 4, number of requesting cores; the design is fixed to 4 and other values are not supported.
- SIZE, 256, RAM depth in words.
- WORD, 32, data word width.
- AW, $clog2(SIZE), address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  CORES  per-core request; core i holds req[i] high until it samples ack[i].
- we_in  in  CORES  per-core access type: 1 = write, 0 = read.
- addr_in  in  CORES*AW  per-core word address; core i occupies bits [i*AW +: AW].
- wdata_in  in  CORES*WORD  per-core write data; core i occupies bits [i*WORD +: WORD].
- ack  out  CORES  one-hot, one-cycle completion pulse to the granted core.
- rdata  out  WORD  read data, shared by all cores; valid while the matching ack bit is high.
- busy  out  1  high whenever the state is not IDLE.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  WORD  RAM write data.
- mem_rdata  in  WORD  RAM read data; high-Z when mem_re is low.

## Operation

- Three-state FSM:
  - IDLE: if any req bit is set, grant the first set bit searching from last_grant+1 upward, wrapping mod 4.
    - Register the winner index, that core's we_in, addr_in and wdata_in into internal registers.
    - Move to ACCESS.
    - With no request, stay in IDLE.
  - ACCESS: drive the RAM pins from the registers.
    - mem_we = registered we.
    - mem_re = the inverse of registered we.
    - mem_addr and mem_wdata come from the registers.
    - On a read, capture mem_rdata into rdata at the end of the cycle.
    - Always move to DONE.
  - DONE: assert ack[winner] for this single cycle.
    - Set last_grant to the winner.
    - Return to IDLE.
- Request inputs are sampled only in IDLE. Changes to req, addr_in, wdata_in or we_in during ACCESS or DONE have no effect on the transaction in flight.
- Core contract: the core clears req[i] on the clock edge that samples ack[i] high. The arbiter therefore never sees a stale req in the IDLE cycle after DONE.
- rdata updates only on reads. A write leaves rdata at its previous value.
- Outside ACCESS, mem_we, mem_re, mem_addr and mem_wdata are all 0. The RAM read port is disabled and the RAM is never written spuriously.
- Fairness: a core that keeps req asserted is served within 4 transactions.
- Asynchronous reset, immediate and at any state:
  - state goes to IDLE.
  - ack, rdata, busy and all mem_* outputs go to 0.
  - last_grant goes to 3, so core 0 has the highest priority after reset.
  - An access aborted during ACCESS is not completed and not acknowledged. The RAM content at that address is undefined for a write that was in flight.

## Timing

- Fixed latency, with E0 the edge on which IDLE samples req:
  - ACCESS occupies the cycle after E0.
  - ack is high for the cycle after E1.
  - The core samples ack and rdata at E2.
- Throughput: one access every 3 cycles. Back-to-back grants go IDLE, ACCESS, DONE, IDLE, ACCESS, and so on; there is no DONE-to-ACCESS bypass.
- mem_* outputs are registered, so the RAM sees stable pins for the whole ACCESS cycle. mem_rdata must settle within that cycle; the RAM is asynchronous.
- ack is one-hot or all zero in every cycle. It is never high for more than one consecutive cycle per transaction.

## Test plan

- Reset, then core 0 writes 0xDEADBEEF to address 0x10.
  - mem_we is high for exactly one cycle with mem_addr = 0x10.
  - ack[0] pulses 2 cycles after the sampling edge.
  - rdata is unchanged at 0.
- Core 2 reads address 0x10 after the write above.
  - mem_re is high for one cycle.
  - ack[2] and rdata = 0xDEADBEEF arrive together.
- All four cores request in the same cycle right after reset.
  - Grant order is 0, 1, 2, 3.
  - The ack pulses are 3 cycles apart.
  - The first one-hot ack is 4'b0001.
- Cores 1 and 3 hold requests continuously after last_grant = 1.
  - Service alternates 3, 1, 3, 1.
  - No core waits more than one transaction.
- Core 0 changes addr_in from 0x20 to 0x30 during ACCESS → mem_addr stays 0x20.
- rst_n is pulled low mid-ACCESS for a read.
  - All outputs go to 0 immediately.
  - No ack is issued.
  - After release, a core 3 request is granted with ack[3].
